iiitb_pwm_capture: RTL

IIITB_PWM_CAPTURE -- requirements
Module: iiitb_pwm_capture

---
 rtl/iiitb_pwm_capture_pkg.sv | 13 +
 rtl/iiitb_pwm_ratio.sv | 76 +++++++
 rtl/iiitb_pwm_capture.sv | 136 +++++++++++++
 3 files changed

// File: rtl/iiitb_pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM encoding and duty resolution.
package iiitb_pwm_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int unsigned DUTY_STEPS = 10;
  localparam int unsigned DUTY_W     = 4;

endpackage

// File: rtl/iiitb_pwm_ratio.sv
// Sequential duty ratio: largest k in 0..DUTY_STEPS with k*period <= 10*high, one k step per cycle.
module iiitb_pwm_ratio
  import iiitb_pwm_capture_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [CNT_W-1:0]  i_high,
  input  logic [CNT_W-1:0]  i_period,
  output logic              o_busy,
  output logic              o_done,
  output logic [DUTY_W-1:0] o_duty,
  output logic [CNT_W-1:0]  o_high,
  output logic [CNT_W-1:0]  o_period
);

  // Handshake: i_start is taken only while o_busy=0 (operands latched that cycle);
  // o_done is a one-cycle strobe and o_duty/o_high/o_period are valid in that cycle;
  // i_abort drops any computation in flight without a done strobe.

  localparam int ACC_W = CNT_W + 4;
  localparam logic [DUTY_W-1:0] K_MAX = DUTY_W'(DUTY_STEPS);

  logic              r_busy;
  logic [DUTY_W-1:0] r_k;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_target;
  logic [CNT_W-1:0]  r_high;
  logic [CNT_W-1:0]  r_period;

  logic [ACC_W-1:0]  w_sum;
  logic              w_fits;
  logic              w_last;

  assign w_sum  = r_acc + ACC_W'(r_period);
  assign w_fits = (w_sum <= r_target) && (r_k < K_MAX);
  // Reaching k=10 ends the search without spending a cycle on a failing compare.
  assign w_last = w_fits && (r_k == K_MAX - 1'b1);

  assign o_busy   = r_busy;
  assign o_done   = r_busy && (!w_fits || w_last);
  assign o_duty   = w_fits ? r_k + 1'b1 : r_k;
  assign o_high   = r_high;
  assign o_period = r_period;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_k      <= '0;
      r_acc    <= '0;
      r_target <= '0;
      r_high   <= '0;
      r_period <= '0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      if (o_done) begin
        r_busy <= 1'b0;
      end else begin
        r_acc <= w_sum;
        r_k   <= r_k + 1'b1;
      end
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_k      <= '0;
      r_acc    <= '0;
      r_target <= ACC_W'(i_high) * ACC_W'(DUTY_STEPS);
      r_high   <= i_high;
      r_period <= i_period;
    end
  end

endmodule

// File: rtl/iiitb_pwm_capture.sv
// PWM capture: synchronizes pwm_in, measures high time and period per cycle, reports duty in tenths,
// and flags a line that has stopped toggling.
module iiitb_pwm_capture
  import iiitb_pwm_capture_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [DUTY_W-1:0] duty_tenths,
  output logic              meas_valid,
  output logic              stuck_hi,
  output logic              stuck_lo,
  output state_t            o_state
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic             r_sync1, r_sync2, r_prev;
  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_high_ctr, r_period_ctr, r_idle_ctr;

  logic              w_rise, w_fall, w_edge, w_timeout, w_capture;
  logic              w_busy, w_done;
  logic [DUTY_W-1:0] w_duty;
  logic [CNT_W-1:0]  w_res_high, w_res_period;

  assign w_rise    = r_sync2 & ~r_prev;
  assign w_fall    = ~r_sync2 & r_prev;
  assign w_edge    = w_rise | w_fall;
  // Fires once on the transition into TIMEOUT; the counter then saturates so it cannot repeat.
  assign w_timeout = !w_edge && (r_idle_ctr == TO_LAST);
  assign w_capture = w_rise && (r_state == ST_LOW);
  assign o_state   = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_rise)                               w_state_next = ST_HIGH;
    else if (w_timeout)                       w_state_next = ST_IDLE;
    else if (r_state == ST_HIGH && w_fall)    w_state_next = ST_LOW;
  end

  // Counters start at 1 on the rise cycle, so the next rise cycle itself is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_high_ctr   <= '0;
      r_period_ctr <= '0;
    end else if (w_rise) begin
      r_high_ctr   <= CNT_W'(1);
      r_period_ctr <= CNT_W'(1);
    end else if (r_state == ST_HIGH && !w_fall) begin
      r_high_ctr   <= sat_inc(r_high_ctr);
      r_period_ctr <= sat_inc(r_period_ctr);
    end else if (r_state != ST_IDLE) begin
      r_period_ctr <= sat_inc(r_period_ctr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_idle_ctr <= '0;
    else if (w_edge)               r_idle_ctr <= '0;
    else if (r_idle_ctr != TO_MAX) r_idle_ctr <= r_idle_ctr + 1'b1;
  end

  iiitb_pwm_ratio #(
    .CNT_W (CNT_W)
  ) u_ratio (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_capture && !w_busy),
    .i_abort  (w_timeout),
    .i_high   (r_high_ctr),
    .i_period (r_period_ctr),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_duty   (w_duty),
    .o_high   (w_res_high),
    .o_period (w_res_period)
  );

  // meas_valid is a strobe with no backpressure; results hold until the next strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt    <= '0;
      period_cnt  <= '0;
      duty_tenths <= '0;
      meas_valid  <= 1'b0;
      stuck_hi    <= 1'b0;
      stuck_lo    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (w_timeout) begin
        high_cnt    <= '0;
        period_cnt  <= '0;
        meas_valid  <= 1'b1;
        duty_tenths <= r_sync2 ? DUTY_W'(DUTY_STEPS) : '0;
        stuck_hi    <= r_sync2;
        stuck_lo    <= ~r_sync2;
      end else if (w_done) begin
        high_cnt    <= w_res_high;
        period_cnt  <= w_res_period;
        duty_tenths <= w_duty;
        meas_valid  <= 1'b1;
        stuck_hi    <= 1'b0;
        stuck_lo    <= 1'b0;
      end
    end
  end

endmodule
